// File: rtl/pipeline_pkg.sv
// Shared encodings and helpers for the pipeline hazard/sequencing controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam logic [4:0] REG_RA          = 5'd31;
  localparam int         MDU_LATENCY_DEF = 32;
  localparam int         MDU_CNT_W       = 6;

  // True when the ID instruction reads register r; $0 never creates a hazard.
  function automatic logic src_hit(input logic [4:0] r,
                                   input logic [4:0] rs,
                                   input logic [4:0] rt,
                                   input logic       use_rs,
                                   input logic       use_rt);
    return (r != REG_ZERO) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multiply/divide busy-window sequencer: IDLE -> BUSY (MDU_LATENCY cycles) -> DONE pulse.
module mdu_sequencer
  import pipeline_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_issue,
  output logic o_busy,
  output logic o_done
);

  localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(MDU_LATENCY - 1);

  mdu_state_t           r_state;
  mdu_state_t           w_state_next;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic [MDU_CNT_W-1:0] w_cnt_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      MDU_IDLE: begin
        if (i_issue) begin
          w_state_next = MDU_BUSY;
          w_cnt_next   = LOAD_VAL;
        end
      end
      MDU_BUSY: begin
        if (r_cnt == '0) w_state_next = MDU_DONE;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      MDU_DONE: begin
        // A back-to-back MDU op may issue in the same cycle the result lands.
        if (i_issue) begin
          w_state_next = MDU_BUSY;
          w_cnt_next   = LOAD_VAL;
        end else begin
          w_state_next = MDU_IDLE;
        end
      end
      default: begin
        w_state_next = MDU_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == MDU_BUSY);
  assign o_done = (r_state == MDU_DONE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, decode-branch and
// HI/LO hazards, MDU sequencing, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       IdRs,
  input  logic [4:0]       IdRt,
  input  logic             IdUsesRs,
  input  logic             IdUsesRt,
  input  logic             IdBranch,
  input  logic             IdJr,
  input  logic             IdJump,
  input  logic             IdMduStart,
  input  logic             IdHiLoRead,
  input  logic             BranchTaken,
  input  logic             ExRegWrite,
  input  logic             ExMemRead,
  input  logic [4:0]       ExRd,
  input  logic             MemRegWrite,
  input  logic             MemMemRead,
  input  logic [4:0]       MemRd,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             BubbleSel,
  output logic             MduBusy,
  output logic             MduDone,
  output logic [CNT_W-1:0] StallCount
);

  logic             w_hit_ex;
  logic             w_hit_mem;
  logic             w_load_use;
  logic             w_branch_haz;
  logic             w_mdu_haz;
  logic             w_stall;
  logic             w_mdu_busy;
  logic             w_mdu_done;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_hit_ex   = src_hit(ExRd,  IdRs, IdRt, IdUsesRs, IdUsesRt);
  assign w_hit_mem  = src_hit(MemRd, IdRs, IdRt, IdUsesRs, IdUsesRt);
  assign w_load_use = ExMemRead & ExRegWrite & w_hit_ex;

  // ALU results in MEM are forwarded into ID, so only a load in MEM stalls a branch.
  assign w_branch_haz = (IdBranch | IdJr) &
                        ((ExRegWrite & w_hit_ex) | (MemMemRead & MemRegWrite & w_hit_mem));
  assign w_mdu_haz    = w_mdu_busy & (IdHiLoRead | IdMduStart);
  assign w_stall      = w_load_use | w_branch_haz | w_mdu_haz;

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    BubbleSel = 1'b0;
    if (!Reset) begin
      if (w_stall) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        BubbleSel = 1'b1;
      end else begin
        IFIDFlush = IdJump | IdJr | (IdBranch & BranchTaken);
      end
    end
  end

  mdu_sequencer #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_seq (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_issue (IdMduStart & ~w_stall),
    .o_busy  (w_mdu_busy),
    .o_done  (w_mdu_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign MduBusy    = w_mdu_busy;
  assign MduDone    = w_mdu_done;
  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the hazard logic plus
// hand-written multi-cycle sequences for MDU timing, reset and counter saturation.
module tb_pipeline_hazard_ctrl;

  logic       Clk, Reset;
  logic [4:0] IdRs, IdRt, ExRd, MemRd;
  logic       IdUsesRs, IdUsesRt, IdBranch, IdJr, IdJump, IdMduStart, IdHiLoRead, BranchTaken;
  logic       ExRegWrite, ExMemRead, MemRegWrite, MemMemRead;
  logic       PCWrite, IFIDWrite, IFIDFlush, BubbleSel, MduBusy, MduDone;
  logic [3:0] StallCount;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .IdRs(IdRs), .IdRt(IdRt), .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
    .IdBranch(IdBranch), .IdJr(IdJr), .IdJump(IdJump), .IdMduStart(IdMduStart),
    .IdHiLoRead(IdHiLoRead), .BranchTaken(BranchTaken), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExRd(ExRd), .MemRegWrite(MemRegWrite), .MemMemRead(MemMemRead),
    .MemRd(MemRd), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .BubbleSel(BubbleSel), .MduBusy(MduBusy), .MduDone(MduDone), .StallCount(StallCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ctl = {urs, urt, br, jr, jmp, taken, exw, exm}; mem = {memw, memm}
  // exp = {PCWrite, IFIDWrite, IFIDFlush, BubbleSel}
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [7:0] ctl;
    logic [4:0] exrd;
    logic [1:0] mem;
    logic [4:0] memrd;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    IdRs = 5'd0; IdRt = 5'd0; IdUsesRs = 1'b0; IdUsesRt = 1'b0;
    IdBranch = 1'b0; IdJr = 1'b0; IdJump = 1'b0; IdMduStart = 1'b0;
    IdHiLoRead = 1'b0; BranchTaken = 1'b0; ExRegWrite = 1'b0; ExMemRead = 1'b0;
    ExRd = 5'd0; MemRegWrite = 1'b0; MemMemRead = 1'b0; MemRd = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    clear_inputs();
    next_cycle();
    Reset = 1'b0;
  endtask

  task automatic chk_ctl(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, PCWrite, IFIDWrite, IFIDFlush, BubbleSel}, {28'd0, exp});
  endtask

  task automatic set_load_use();
    ExMemRead = 1'b1; ExRegWrite = 1'b1; ExRd = 5'd8;
    IdRs = 5'd8; IdUsesRs = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_cnt;

    vecs[0]  = '{5'd0,  5'd0, 8'b0000_0000, 5'd0,  2'b00, 5'd0, 4'b1100};
    vecs[1]  = '{5'd8,  5'd0, 8'b1000_0011, 5'd8,  2'b00, 5'd0, 4'b0001};
    vecs[2]  = '{5'd3,  5'd8, 8'b1100_0011, 5'd8,  2'b00, 5'd0, 4'b0001};
    vecs[3]  = '{5'd8,  5'd0, 8'b0000_0011, 5'd8,  2'b00, 5'd0, 4'b1100};
    vecs[4]  = '{5'd0,  5'd0, 8'b1100_0011, 5'd0,  2'b00, 5'd0, 4'b1100};
    vecs[5]  = '{5'd8,  5'd0, 8'b1000_0001, 5'd8,  2'b00, 5'd0, 4'b1100};
    vecs[6]  = '{5'd9,  5'd0, 8'b1010_0110, 5'd9,  2'b00, 5'd0, 4'b0001};
    vecs[7]  = '{5'd9,  5'd0, 8'b1010_0100, 5'd0,  2'b10, 5'd9, 4'b1110};
    vecs[8]  = '{5'd9,  5'd0, 8'b1010_0100, 5'd0,  2'b11, 5'd9, 4'b0001};
    vecs[9]  = '{5'd9,  5'd4, 8'b1110_0000, 5'd0,  2'b00, 5'd0, 4'b1100};
    vecs[10] = '{5'd0,  5'd0, 8'b0000_1000, 5'd0,  2'b00, 5'd0, 4'b1110};
    vecs[11] = '{5'd31, 5'd0, 8'b1001_0010, 5'd31, 2'b00, 5'd0, 4'b0001};
    vecs[12] = '{5'd31, 5'd0, 8'b1001_0000, 5'd0,  2'b00, 5'd0, 4'b1110};
    vecs[13] = '{5'd5,  5'd0, 8'b1000_0010, 5'd5,  2'b00, 5'd0, 4'b1100};
    vecs[14] = '{5'd5,  5'd0, 8'b1000_0000, 5'd0,  2'b11, 5'd5, 4'b1100};
    vecs[15] = '{5'd2,  5'd6, 8'b1110_0100, 5'd0,  2'b11, 5'd6, 4'b0001};

    // Reset state, with a load-use pattern present that must be overridden.
    Reset = 1'b1;
    clear_inputs();
    next_cycle();
    set_load_use();
    @(negedge Clk);
    chk_ctl("reset_ctl", 4'b1100);
    chk("reset_cnt",  {28'd0, StallCount}, 32'd0);
    chk("reset_busy", {31'd0, MduBusy},    32'd0);
    chk("reset_done", {31'd0, MduDone},    32'd0);
    next_cycle();
    Reset = 1'b0;
    clear_inputs();

    // Table of single-cycle hazard patterns with a running stall count.
    exp_cnt = 4'd0;
    for (int i = 0; i < 16; i++) begin
      IdRs = vecs[i].rs;
      IdRt = vecs[i].rt;
      {IdUsesRs, IdUsesRt, IdBranch, IdJr, IdJump, BranchTaken, ExRegWrite, ExMemRead} = vecs[i].ctl;
      ExRd = vecs[i].exrd;
      {MemRegWrite, MemMemRead} = vecs[i].mem;
      MemRd = vecs[i].memrd;
      @(negedge Clk);
      chk_ctl($sformatf("vec%0d_ctl", i), vecs[i].exp);
      chk($sformatf("vec%0d_cnt", i), {28'd0, StallCount}, {28'd0, exp_cnt});
      if (vecs[i].exp[0] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      next_cycle();
    end
    clear_inputs();
    @(negedge Clk);
    chk("table_final_cnt", {28'd0, StallCount}, {28'd0, exp_cnt});
    next_cycle();

    // lw in EX feeding add in ID: one bubble, then proceeds with lw in MEM.
    do_reset();
    set_load_use();
    @(negedge Clk);
    chk_ctl("lu_stall", 4'b0001);
    next_cycle();
    ExMemRead = 1'b0; ExRegWrite = 1'b0; ExRd = 5'd0;
    MemMemRead = 1'b1; MemRegWrite = 1'b1; MemRd = 5'd8;
    @(negedge Clk);
    chk_ctl("lu_release", 4'b1100);
    chk("lu_cnt", {28'd0, StallCount}, 32'd1);
    next_cycle();

    // beq on lw result: stall in EX, stall in MEM, then flush on taken branch.
    do_reset();
    IdBranch = 1'b1; IdRs = 5'd9; IdUsesRs = 1'b1; BranchTaken = 1'b1;
    ExMemRead = 1'b1; ExRegWrite = 1'b1; ExRd = 5'd9;
    @(negedge Clk);
    chk_ctl("brlw_ex", 4'b0001);
    next_cycle();
    ExMemRead = 1'b0; ExRegWrite = 1'b0; ExRd = 5'd0;
    MemMemRead = 1'b1; MemRegWrite = 1'b1; MemRd = 5'd9;
    @(negedge Clk);
    chk_ctl("brlw_mem", 4'b0001);
    next_cycle();
    MemMemRead = 1'b0; MemRegWrite = 1'b0; MemRd = 5'd0;
    @(negedge Clk);
    chk_ctl("brlw_flush", 4'b1110);
    chk("brlw_cnt", {28'd0, StallCount}, 32'd2);
    next_cycle();

    // mult issue at cycle 0; add at 1; mflo held from 2 stalls until DONE at 5.
    do_reset();
    IdMduStart = 1'b1;
    @(negedge Clk);
    chk_ctl("mdu_issue", 4'b1100);
    chk("mdu_c0_busy", {31'd0, MduBusy}, 32'd0);
    next_cycle();
    clear_inputs();
    IdRs = 5'd3; IdUsesRs = 1'b1;
    @(negedge Clk);
    chk("mdu_c1_busy", {31'd0, MduBusy}, 32'd1);
    chk_ctl("mdu_add_free", 4'b1100);
    next_cycle();
    clear_inputs();
    IdHiLoRead = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge Clk);
      chk($sformatf("mdu_c%0d_busy", c), {31'd0, MduBusy}, 32'd1);
      chk($sformatf("mdu_c%0d_done", c), {31'd0, MduDone}, 32'd0);
      chk_ctl($sformatf("mdu_c%0d_mflo", c), 4'b0001);
      next_cycle();
    end
    @(negedge Clk);
    chk("mdu_c5_done", {31'd0, MduDone}, 32'd1);
    chk("mdu_c5_busy", {31'd0, MduBusy}, 32'd0);
    chk_ctl("mdu_c5_mflo", 4'b1100);
    chk("mdu_cnt", {28'd0, StallCount}, 32'd3);
    next_cycle();
    clear_inputs();
    @(negedge Clk);
    chk("mdu_c6_done", {31'd0, MduDone}, 32'd0);

    // Second mult issued at cycle 6; a third issues in its DONE cycle (11).
    IdMduStart = 1'b1;
    next_cycle();
    clear_inputs();
    repeat (4) next_cycle();
    IdMduStart = 1'b1;
    @(negedge Clk);
    chk("reissue_done", {31'd0, MduDone}, 32'd1);
    chk_ctl("reissue_nostall", 4'b1100);
    next_cycle();
    clear_inputs();
    @(negedge Clk);
    chk("reissue_busy", {31'd0, MduBusy}, 32'd1);
    chk("reissue_done_clr", {31'd0, MduDone}, 32'd0);
    next_cycle();

    // Reset mid-BUSY with cnt=2, while an mflo would otherwise stall.
    do_reset();
    IdMduStart = 1'b1;
    next_cycle();
    clear_inputs();
    next_cycle();
    Reset = 1'b1;
    IdHiLoRead = 1'b1;
    @(negedge Clk);
    chk_ctl("rst_mid_ctl", 4'b1100);
    next_cycle();
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid_busy", {31'd0, MduBusy}, 32'd0);
    chk("rst_mid_cnt", {28'd0, StallCount}, 32'd0);
    chk_ctl("rst_mid_mflo", 4'b1100);
    next_cycle();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      chk($sformatf("rst_idle_done%0d", c), {31'd0, MduDone}, 32'd0);
      chk($sformatf("rst_idle_busy%0d", c), {31'd0, MduBusy}, 32'd0);
      next_cycle();
    end

    // Counter saturation at 4'hF under a held load-use stall.
    do_reset();
    set_load_use();
    repeat (20) next_cycle();
    @(negedge Clk);
    chk("sat_cnt", {28'd0, StallCount}, 32'hF);
    chk_ctl("sat_ctl", 4'b0001);
    next_cycle();
    @(negedge Clk);
    chk("sat_hold", {28'd0, StallCount}, 32'hF);
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
